// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, requester count and request payload.
// Used by alu, alu_arbiter_if and alu_arbiter.
package alu_pkg;

  localparam int unsigned NUM_ALU_REQ   = 2;
  localparam int unsigned ALU_XLEN      = 64;
  localparam int unsigned ALU_OP_W      = 7;
  // Tag field is sized for the widest supported caller tag; narrower tags zero-extend.
  localparam int unsigned ALU_TAG_MAX_W = 16;

  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 7'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 7'd1;
  localparam logic [ALU_OP_W-1:0] ALU_ADDW = 7'd2;
  localparam logic [ALU_OP_W-1:0] ALU_SUBW = 7'd3;
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = 7'd4;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 7'd5;
  localparam logic [ALU_OP_W-1:0] ALU_AND  = 7'd6;
  localparam logic [ALU_OP_W-1:0] ALU_SRA  = 7'd7;
  localparam logic [ALU_OP_W-1:0] ALU_SRL  = 7'd8;
  localparam logic [ALU_OP_W-1:0] ALU_SLL  = 7'd9;
  localparam logic [ALU_OP_W-1:0] ALU_SRLW = 7'd10;
  localparam logic [ALU_OP_W-1:0] ALU_SLLW = 7'd11;
  localparam logic [ALU_OP_W-1:0] ALU_SRAW = 7'd12;
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = 7'd21;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = 7'd22;

  typedef logic [ALU_OP_W-1:0] alu_op_t;

  typedef struct packed {
    logic [ALU_XLEN-1:0]      rs1;
    logic [ALU_XLEN-1:0]      rs2;
    alu_op_t                  op;
    logic [ALU_TAG_MAX_W-1:0] tag;
  } alu_req_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bus of the shared ALU arbiter.
// slave modport: arbiter side (takes requests, drives responses and grant counters).
// master modport: requester/consumer side.
interface alu_arbiter_if
  import alu_pkg::*;
#(
  parameter int unsigned TAG_W = 4,
  parameter int unsigned XLEN  = 64
);

  logic                   flush_i;
  logic [NUM_ALU_REQ-1:0] req_valid_i;
  logic [NUM_ALU_REQ-1:0] req_ready_o;
  logic [XLEN-1:0]        req0_rs1_i;
  logic [XLEN-1:0]        req0_rs2_i;
  logic [ALU_OP_W-1:0]    req0_op_i;
  logic [TAG_W-1:0]       req0_tag_i;
  logic [XLEN-1:0]        req1_rs1_i;
  logic [XLEN-1:0]        req1_rs2_i;
  logic [ALU_OP_W-1:0]    req1_op_i;
  logic [TAG_W-1:0]       req1_tag_i;
  logic                   resp_valid_o;
  logic                   resp_ready_i;
  logic                   resp_id_o;
  logic [TAG_W-1:0]       resp_tag_o;
  logic [XLEN-1:0]        resp_result_o;
  logic [31:0]            grant_cnt0_o;
  logic [31:0]            grant_cnt1_o;

  modport slave (
    input  flush_i, req_valid_i,
    input  req0_rs1_i, req0_rs2_i, req0_op_i, req0_tag_i,
    input  req1_rs1_i, req1_rs2_i, req1_op_i, req1_tag_i,
    input  resp_ready_i,
    output req_ready_o, resp_valid_o, resp_id_o, resp_tag_o, resp_result_o,
    output grant_cnt0_o, grant_cnt1_o
  );

  modport master (
    output flush_i, req_valid_i,
    output req0_rs1_i, req0_rs2_i, req0_op_i, req0_tag_i,
    output req1_rs1_i, req1_rs2_i, req1_op_i, req1_tag_i,
    output resp_ready_i,
    input  req_ready_o, resp_valid_o, resp_id_o, resp_tag_o, resp_result_o,
    input  grant_cnt0_o, grant_cnt1_o
  );

endinterface

// File: rtl/alu.sv
// Combinational single-cycle scalar ALU.
// Ports: rs1, rs2 operands; op operation code; result_c combinational result
// (unknown op codes return 0).
module alu
  import alu_pkg::*;
(
  input  logic [ALU_XLEN-1:0] rs1,
  input  logic [ALU_XLEN-1:0] rs2,
  input  alu_op_t             op,
  output logic [ALU_XLEN-1:0] result_c
);

  logic [31:0] w_c;
  logic [5:0]  sh_c;
  logic [4:0]  shw_c;

  assign sh_c  = rs2[5:0];
  assign shw_c = rs2[4:0];

  // Operation decode; W-ops build a 32-bit result in w_c and sign-extend it.
  always_comb begin
    result_c = '0;
    w_c      = '0;
    case (op)
      ALU_ADD:  result_c = rs1 + rs2;
      ALU_SUB:  result_c = rs1 - rs2;
      ALU_ADDW: begin
        w_c      = rs1[31:0] + rs2[31:0];
        result_c = {{32{w_c[31]}}, w_c};
      end
      ALU_SUBW: begin
        w_c      = rs1[31:0] - rs2[31:0];
        result_c = {{32{w_c[31]}}, w_c};
      end
      ALU_XOR:  result_c = rs1 ^ rs2;
      ALU_OR:   result_c = rs1 | rs2;
      ALU_AND:  result_c = rs1 & rs2;
      ALU_SRA:  result_c = $unsigned($signed(rs1) >>> sh_c);
      ALU_SRL:  result_c = rs1 >> sh_c;
      ALU_SLL:  result_c = rs1 << sh_c;
      ALU_SRLW: begin
        w_c      = rs1[31:0] >> shw_c;
        result_c = {{32{w_c[31]}}, w_c};
      end
      ALU_SLLW: begin
        w_c      = rs1[31:0] << shw_c;
        result_c = {{32{w_c[31]}}, w_c};
      end
      ALU_SRAW: begin
        w_c      = $unsigned($signed(rs1[31:0]) >>> shw_c);
        result_c = {{32{w_c[31]}}, w_c};
      end
      ALU_SLT:  result_c = ALU_XLEN'($signed(rs1) < $signed(rs2));
      ALU_SLTU: result_c = ALU_XLEN'(rs1 < rs2);
      default:  result_c = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two valid/ready requesters, with a
// single registered response slot tagged by requester id and caller tag.
// Ports: clk_i clock; rstn_i async active-low reset; bus (alu_arbiter_if.slave)
// carrying flush, requests, ready, response slot and grant counters.
// Optional: ALU_ARB_PERF_EN enables per-requester accepted-request counters;
// otherwise the counter outputs are tied to 0.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned TAG_W = 4,
  parameter int unsigned XLEN  = 64
)(
  input  logic         clk_i,
  input  logic         rstn_i,
  alu_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = 32;

  alu_req_t         req0_c;
  alu_req_t         req1_c;
  alu_req_t         gnt_req_c;
  logic [1:0]       grant_c;
  logic [1:0]       req_ready_c;
  logic             free_c;
  logic             accept_c;
  logic             gnt_id_c;
  logic [XLEN-1:0]  alu_res_c;

  logic             valid_q,  valid_d;
  logic             id_q,     id_d;
  logic             last_q,   last_d;
  logic [TAG_W-1:0] tag_q,    tag_d;
  logic [XLEN-1:0]  result_q, result_d;

  assign req0_c = '{rs1: bus.req0_rs1_i, rs2: bus.req0_rs2_i, op: bus.req0_op_i,
                    tag: ALU_TAG_MAX_W'(bus.req0_tag_i)};
  assign req1_c = '{rs1: bus.req1_rs1_i, rs2: bus.req1_rs2_i, op: bus.req1_op_i,
                    tag: ALU_TAG_MAX_W'(bus.req1_tag_i)};

  // Grant: a lone requester wins; on a tie the one not accepted last wins.
  always_comb begin
    grant_c = 2'b00;
    case (bus.req_valid_i)
      2'b01:   grant_c = 2'b01;
      2'b10:   grant_c = 2'b10;
      2'b11:   grant_c = last_q ? 2'b01 : 2'b10;
      default: grant_c = 2'b00;
    endcase
  end

  // Slot can take a new result when empty or being drained this cycle.
  assign free_c      = ~valid_q | bus.resp_ready_i;
  assign req_ready_c = grant_c & {2{free_c & ~bus.flush_i & rstn_i}};
  assign accept_c    = |(bus.req_valid_i & req_ready_c);
  assign gnt_id_c    = grant_c[1];
  assign gnt_req_c   = gnt_id_c ? req1_c : req0_c;

  alu u_alu (
    .rs1      (gnt_req_c.rs1),
    .rs2      (gnt_req_c.rs2),
    .op       (gnt_req_c.op),
    .result_c (alu_res_c)
  );

  // Slot next state: flush wins, then accept (reload), then drain.
  always_comb begin
    valid_d  = valid_q;
    id_d     = id_q;
    tag_d    = tag_q;
    result_d = result_q;
    last_d   = last_q;
    if (bus.flush_i) begin
      valid_d = 1'b0;
    end else if (accept_c) begin
      valid_d  = 1'b1;
      id_d     = gnt_id_c;
      tag_d    = TAG_W'(gnt_req_c.tag);
      result_d = alu_res_c;
      last_d   = gnt_id_c;
    end else if (bus.resp_ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Slot and round-robin state registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      valid_q  <= 1'b0;
      id_q     <= 1'b0;
      tag_q    <= '0;
      result_q <= '0;
      last_q   <= 1'b1;
    end else begin
      valid_q  <= valid_d;
      id_q     <= id_d;
      tag_q    <= tag_d;
      result_q <= result_d;
      last_q   <= last_d;
    end
  end

  assign bus.req_ready_o   = req_ready_c;
  assign bus.resp_valid_o  = valid_q;
  assign bus.resp_id_o     = id_q;
  assign bus.resp_tag_o    = tag_q;
  assign bus.resp_result_o = result_q;

`ifdef ALU_ARB_PERF_EN
  logic [CNT_W-1:0] grant_cnt0_q;
  logic [CNT_W-1:0] grant_cnt1_q;

  // Accepted-request counters; wrap naturally and ignore flush.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      grant_cnt0_q <= '0;
      grant_cnt1_q <= '0;
    end else begin
      if (accept_c && !gnt_id_c) grant_cnt0_q <= grant_cnt0_q + CNT_W'(1);
      if (accept_c &&  gnt_id_c) grant_cnt1_q <= grant_cnt1_q + CNT_W'(1);
    end
  end

  assign bus.grant_cnt0_o = grant_cnt0_q;
  assign bus.grant_cnt1_o = grant_cnt1_q;
`else
  assign bus.grant_cnt0_o = CNT_W'(0);
  assign bus.grant_cnt1_o = CNT_W'(0);
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed scenarios plus random traffic,
// expected responses queued at acceptance and compared by a separate monitor.
module tb_alu_arbiter;
  import alu_pkg::*;

  typedef struct {
    int          id;
    logic [3:0]  tag;
    logic [63:0] res;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  int   checks = 0;
  int   failures = 0;
  bit   chk_en = 1'b0;
  int   last_id = 1;
  int   mcnt [2];
  exp_t sbq [$];
  int   ops_l [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 21, 22, 50};

  alu_arbiter_if #(.TAG_W(4), .XLEN(64)) bus ();

  alu_arbiter #(.TAG_W(4), .XLEN(64)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] sext32(logic [31:0] w);
    return {{32{w[31]}}, w};
  endfunction

  // Reference ALU from the operation table.
  function automatic logic [63:0] ref_alu(int op, logic [63:0] a, logic [63:0] b);
    logic [31:0] a32, b32;
    a32 = a[31:0];
    b32 = b[31:0];
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return sext32(a32 + b32);
      3:  return sext32(a32 - b32);
      4:  return a ^ b;
      5:  return a | b;
      6:  return a & b;
      7:  return $signed(a) >>> b[5:0];
      8:  return a >> b[5:0];
      9:  return a << b[5:0];
      10: return sext32(a32 >> b[4:0]);
      11: return sext32(a32 << b[4:0]);
      12: return sext32($signed(a32) >>> b[4:0]);
      21: return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      22: return (a < b) ? 64'd1 : 64'd0;
      default: return 64'd0;
    endcase
  endfunction

  // Winner among the valid requesters, -1 when none.
  function automatic int exp_grant(logic [1:0] v, int last);
    if (v == 2'b00) return -1;
    if (v == 2'b01) return 0;
    if (v == 2'b10) return 1;
    return 1 - last;
  endfunction

  // Model step at the clock edge: accept into an empty slot, or flush it.
  task automatic model_edge();
    int g;
    if (!rstn) return;
    g = exp_grant(bus.req_valid_i, last_id);
    if (bus.flush_i) begin
      sbq.delete();
    end else if (g >= 0 && sbq.size() == 0) begin
      exp_t e;
      e.id = g;
      if (g == 0) begin
        e.tag = bus.req0_tag_i;
        e.res = ref_alu(int'(bus.req0_op_i), bus.req0_rs1_i, bus.req0_rs2_i);
      end else begin
        e.tag = bus.req1_tag_i;
        e.res = ref_alu(int'(bus.req1_op_i), bus.req1_rs1_i, bus.req1_rs2_i);
      end
      sbq.push_back(e);
      last_id = g;
      mcnt[g]++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_req(int r, int op, logic [63:0] a, logic [63:0] b, logic [3:0] t);
    if (r == 0) begin
      bus.req0_op_i = 7'(op); bus.req0_rs1_i = a; bus.req0_rs2_i = b; bus.req0_tag_i = t;
    end else begin
      bus.req1_op_i = 7'(op); bus.req1_rs1_i = a; bus.req1_rs2_i = b; bus.req1_tag_i = t;
    end
  endtask

  // Monitor: ready check, then slot compare and pop on drain.
  initial begin
    int         g;
    logic [1:0] exp_rdy;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        g = exp_grant(bus.req_valid_i, last_id);
        exp_rdy = 2'b00;
        if (g >= 0 && (sbq.size() == 0 || bus.resp_ready_i) && !bus.flush_i) exp_rdy[g] = 1'b1;
        check("req_ready", 64'(bus.req_ready_o), 64'(exp_rdy));
        check("resp_valid", 64'(bus.resp_valid_o), 64'(sbq.size() != 0));
        if (sbq.size() != 0) begin
          e = sbq[0];
          if (bus.resp_valid_o) begin
            check("resp_id", 64'(bus.resp_id_o), 64'(e.id));
            check("resp_tag", 64'(bus.resp_tag_o), 64'(e.tag));
            check("resp_result", bus.resp_result_o, e.res);
          end
          if (bus.resp_ready_i) void'(sbq.pop_front());
        end
      end
    end
  end

  initial begin
    logic [63:0] exp_cnt0, exp_cnt1;
    int          pat [4] = '{0, 1, 0, 1};
    mcnt = '{0, 0};
    rstn = 1'b0;
    bus.flush_i = 1'b0;
    bus.req_valid_i = 2'b11;
    bus.resp_ready_i = 1'b1;
    set_req(0, 0, 64'd0, 64'd0, 4'd0);
    set_req(1, 0, 64'd0, 64'd0, 4'd0);

    // Reset state.
    repeat (3) tick();
    @(negedge clk);
    check("rst_ready", 64'(bus.req_ready_o), 64'd0);
    check("rst_valid", 64'(bus.resp_valid_o), 64'd0);
    check("rst_id", 64'(bus.resp_id_o), 64'd0);
    check("rst_tag", 64'(bus.resp_tag_o), 64'd0);
    check("rst_result", bus.resp_result_o, 64'd0);
    check("rst_cnt0", 64'(bus.grant_cnt0_o), 64'd0);
    check("rst_cnt1", 64'(bus.grant_cnt1_o), 64'd0);
    tick();
    rstn = 1'b1;
    chk_en = 1'b1;

    // Single request: ADD 5+7 tag 3.
    bus.req_valid_i = 2'b01;
    set_req(0, 0, 64'd5, 64'd7, 4'd3);
    tick();
    bus.req_valid_i = 2'b00;
    @(negedge clk);
    check("single_valid", 64'(bus.resp_valid_o), 64'd1);
    check("single_result", bus.resp_result_o, 64'd12);
    check("single_id", 64'(bus.resp_id_o), 64'd0);
    check("single_tag", 64'(bus.resp_tag_o), 64'd3);

    // Requester 1 once so the tie starts with requester 0.
    bus.req_valid_i = 2'b10;
    set_req(1, 3, 64'd0, 64'd1, 4'd9);
    tick();

    // Contention: alternating grants, SUBW(0,1) from requester 1.
    bus.req_valid_i = 2'b11;
    set_req(0, 0, 64'd2, 64'd2, 4'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge clk);
      check("rr_id", 64'(bus.resp_id_o), 64'(pat[k]));
      if (pat[k] == 1) check("subw_result", bus.resp_result_o, 64'hFFFF_FFFF_FFFF_FFFF);
    end
    @(posedge clk); model_edge(); #1;

    // Backpressure: SLT(-1,1) held with slot full.
    bus.req_valid_i = 2'b00;
    tick();
    bus.req_valid_i = 2'b01;
    set_req(0, 21, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'd5);
    bus.resp_ready_i = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_ready", 64'(bus.req_ready_o), 64'd0);
      check("bp_result", bus.resp_result_o, 64'd1);
      tick();
    end
    bus.resp_ready_i = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 64'(bus.req_ready_o), 64'd1);
    tick();

    // Flush with slot valid and requester 1 valid.
    bus.resp_ready_i = 1'b0;
    bus.flush_i = 1'b1;
    bus.req_valid_i = 2'b10;
    set_req(1, 4, 64'hF0, 64'h0F, 4'd7);
    @(negedge clk);
    check("flush_ready", 64'(bus.req_ready_o), 64'd0);
    tick();
    bus.flush_i = 1'b0;
    bus.req_valid_i = 2'b00;
    @(negedge clk);
    check("flush_valid", 64'(bus.resp_valid_o), 64'd0);
    bus.req_valid_i = 2'b11;
    bus.resp_ready_i = 1'b1;
    tick();
    bus.req_valid_i = 2'b00;
    @(negedge clk);
    check("flush_last_kept", 64'(bus.resp_id_o), 64'd1);

    // Reset mid-stream.
    bus.req_valid_i = 2'b01;
    set_req(0, 0, 64'd1, 64'd1, 4'd2);
    tick();
    bus.req_valid_i = 2'b00;
    bus.resp_ready_i = 1'b0;
    #2;
    chk_en = 1'b0;
    rstn = 1'b0;
    #1;
    check("midrst_valid", 64'(bus.resp_valid_o), 64'd0);
    check("midrst_ready", 64'(bus.req_ready_o), 64'd0);
    sbq.delete();
    last_id = 1;
    mcnt = '{0, 0};
    bus.req_valid_i = 2'b11;
    repeat (2) tick();
    rstn = 1'b1;
    chk_en = 1'b1;
    bus.resp_ready_i = 1'b1;
    tick();
    @(negedge clk);
    check("midrst_tie_id", 64'(bus.resp_id_o), 64'd0);

    // Counters: three accepts from 0, two from 1.
    bus.req_valid_i = 2'b01;
    repeat (2) tick();
    bus.req_valid_i = 2'b10;
    repeat (2) tick();
    bus.req_valid_i = 2'b00;
    @(negedge clk);
`ifdef ALU_ARB_PERF_EN
    exp_cnt0 = 64'd3; exp_cnt1 = 64'd2;
`else
    exp_cnt0 = 64'd0; exp_cnt1 = 64'd0;
`endif
    check("cnt0", 64'(bus.grant_cnt0_o), exp_cnt0);
    check("cnt1", 64'(bus.grant_cnt1_o), exp_cnt1);
    tick();
`ifdef ALU_ARB_PERF_EN
    // Wrap from all-ones.
    force dut.grant_cnt0_q = 32'hFFFF_FFFF;
    #1;
    release dut.grant_cnt0_q;
    bus.req_valid_i = 2'b01;
    tick();
    bus.req_valid_i = 2'b00;
    @(negedge clk);
    check("cnt0_wrap", 64'(bus.grant_cnt0_o), 64'd0);
    mcnt[0] = 0;
    tick();
`endif

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      bus.req_valid_i = 2'($urandom_range(0, 3));
      bus.resp_ready_i = ($urandom_range(0, 3) != 0);
      bus.flush_i = ($urandom_range(0, 15) == 0);
      for (int r = 0; r < 2; r++) begin
        logic [63:0] a, b;
        a = {$urandom, $urandom};
        b = ($urandom_range(0, 1) != 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 70));
        set_req(r, ops_l[$urandom_range(0, 15)], a, b, 4'($urandom_range(0, 15)));
      end
      tick();
    end

    // Drain and final counters.
    bus.req_valid_i = 2'b00;
    bus.flush_i = 1'b0;
    bus.resp_ready_i = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("final_valid", 64'(bus.resp_valid_o), 64'd0);
`ifdef ALU_ARB_PERF_EN
    exp_cnt0 = 64'(mcnt[0]); exp_cnt1 = 64'(mcnt[1]);
`else
    exp_cnt0 = 64'd0; exp_cnt1 = 64'd0;
`endif
    check("final_cnt0", 64'(bus.grant_cnt0_o), exp_cnt0);
    check("final_cnt1", 64'(bus.grant_cnt1_o), exp_cnt1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single-cycle scalar ALU between two requesters (requester 0: the scalar integer pipeline; requester 1: the address/auxiliary issue path). Each requester uses a valid/ready handshake. A round-robin arbiter grants one request per cycle, and the ALU result is captured in one registered response slot tagged with the requester id and a caller tag. Full throughput is one operation per cycle when the consumer is always ready.

## Interface
Parameters:
- TAG_W, default 4: width of the caller tag carried with each request.
- XLEN, default 64: operand and result width. Only 64 is supported.

Ports:
- clk_i, in, 1: clock; all state updates on the rising edge.
- rstn_i, in, 1: reset, asynchronous, active-low.
- flush_i, in, 1: discards the response slot and blocks acceptance this cycle.
- req_valid_i, in, 2: request valid, bit i for requester i.
- req_ready_o, out, 2: request accepted this cycle, bit i for requester i.
- req0_rs1_i / req1_rs1_i, in, XLEN: operand 1.
- req0_rs2_i / req1_rs2_i, in, XLEN: operand 2.
- req0_op_i / req1_op_i, in, 7: ALU operation code.
- req0_tag_i / req1_tag_i, in, TAG_W: caller tag.
- resp_valid_o, out, 1: response slot holds a result.
- resp_ready_i, in, 1: consumer takes the response.
- resp_id_o, out, 1: requester that issued the result.
- resp_tag_o, out, TAG_W: tag of the result.
- resp_result_o, out, XLEN: ALU result.
- grant_cnt0_o / grant_cnt1_o, out, 32: accepted-request counters (see Configuration).

## Operation
- Operation codes: ADD 0, SUB 1, ADDW 2, SUBW 3, XOR 4, OR 5, AND 6, SRA 7, SRL 8, SLL 9, SRLW 10, SLLW 11, SRAW 12, SLT 21, SLTU 22.
  - W-ops sign-extend bit 31 of the 32-bit result.
  - 64-bit shifts use rs2[5:0]; W shifts use rs2[4:0].
  - Any other code yields result 0. It is still accepted and returned, not an error.
- Slot free: `free = ~resp_valid_o | resp_ready_i`.
- Grant:
  - If exactly one requester is valid, it wins.
  - If both are valid, the requester not accepted most recently wins. This is tracked by a 1-bit `last_q` register.
- Acceptance: `req_ready_o[i] = grant[i] & free & ~flush_i`. Accept when `req_valid_i[i] & req_ready_o[i]`; at most one bit is ever set.
- On accept:
  - The ALU evaluates the granted operands combinationally.
  - The result, id and tag load into the slot.
  - resp_valid_o is 1 next cycle.
  - `last_q` is set to the granted id.
- No accept and resp_ready_i = 1: resp_valid_o clears next cycle.
- Both in one cycle (consumer drains and a new request is accepted): the slot reloads with the new result; resp_valid_o stays 1.
- flush_i = 1: resp_valid_o clears next cycle, no accept occurs, and `last_q` is unchanged.
- Output stability: while resp_valid_o = 1 and resp_ready_i = 0, all resp_* outputs hold.
- Handshake dependency: req_ready_o depends combinationally on req_valid_i and resp_ready_i. Requesters must not derive valid from ready.

## Timing
- Latency: accept at edge N, result on resp_* during cycle N+1.
- Throughput: 1 operation per cycle.
- Reset values:
  - req_ready_o = 0 while in reset.
  - resp_valid_o = 0, resp_id_o = 0, resp_tag_o = 0, resp_result_o = 0.
  - `last_q` = 1, so requester 0 has priority first.
  - Grant counters = 0.
- Reset asserted mid-operation: the slot and counters clear immediately (asynchronous); the pending result is lost.
- Deassertion of rstn_i is synchronized externally. The first accept can occur on the first edge after release.

## Configuration
- ALU_ARB_PERF_EN defined:
  - grant_cnt0_o / grant_cnt1_o increment by 1 on each accept from requester 0 / 1.
  - Counters wrap from 32'hFFFF_FFFF to 0.
  - Counters are not cleared by flush_i.
- Not defined: both counter ports are tied to 0 and no counter flops exist.

## Structure
- Shared package alu_pkg holds:
  - the 7-bit operation-code constants above;
  - a constant NUM_ALU_REQ = 2;
  - the request struct typedef {rs1, rs2, op, tag}.
- Sub-module: alu, the existing combinational ALU, instantiated once on the granted operands. Arbitration and the slot register stay in alu_arbiter.

## Test plan
- Single request:
  - Stimulus: requester 0, ADD with rs1 = 5, rs2 = 7, tag 3, resp_ready_i held 1.
  - Required: next cycle resp_valid_o = 1, result 12, id 0, tag 3.
- Contention: both requesters valid for 4 cycles with resp_ready_i = 1.
  - Required: grants alternate 0, 1, 0, 1.
  - Required: requester 1 SUBW with rs1 = 0, rs2 = 1 returns 64'hFFFF_FFFF_FFFF_FFFF.
- Backpressure:
  - Stimulus: resp_ready_i = 0 with the slot full and SLT(-1, 1) held.
  - Required: req_ready_o = 0; resp outputs hold result 1 until resp_ready_i rises; the next accept happens in that same cycle.
- Flush:
  - Stimulus: flush_i asserted with the slot valid and requester 1 valid.
  - Required: resp_valid_o = 0 next cycle; no accept; `last_q` unchanged.
- Reset mid-stream:
  - Stimulus: drop rstn_i while resp_valid_o = 1.
  - Required: resp_valid_o = 0 immediately; after release, requester 0 wins the first tie.
- Counters (ALU_ARB_PERF_EN defined):
  - Stimulus: 3 accepts from requester 0 and 2 from requester 1.
  - Required: grant_cnt0_o = 3, grant_cnt1_o = 2. With a counter preset by force to 32'hFFFF_FFFF, one accept yields 0.
  - Not defined: both counters read 0.
